// File: rtl/jk_pkg.sv
// Shared types and J/K excitation encodings for the J-K flop drive controller.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } jkdrv_state_t;

  // Excitation pairs encoded as {j,k}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation lookup from current and requested q.
// JKDRV_TOGGLE_EN: encode any required change as toggle instead of set/reset.
module jk_excite
  import jk_pkg::*;
(
  input  logic       q_cur,
  input  logic       q_next,
  output logic [1:0] jk
);

  always_comb begin
    jk = JK_HOLD;
    if (q_cur != q_next) begin
`ifdef JKDRV_TOGGLE_EN
      jk = JK_TOGGLE;
`else
      jk = q_next ? JK_SET : JK_RESET;
`endif
    end
  end

endmodule

// File: rtl/jk_drive_ctrl.sv
// Drives a discrete J-K flop to each requested bit, then reads q back and flags mismatches.
// JKDRV_TOGGLE_EN (in jk_excite) selects toggle encoding for required changes.
module jk_drive_ctrl
  import jk_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int CHK_DLY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_in,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  localparam logic [3:0] DLY_LOAD = 4'(CHK_DLY);

  jkdrv_state_t state;
  logic         tgt_q;
  logic [3:0]   dly_cnt;
  logic [1:0]   jk_calc;

  jk_excite u_excite (
    .q_cur  (q_in),
    .q_next (tgt_bit),
    .jk     (jk_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt_q     <= 1'b0;
      dly_cnt   <= 4'd0;
      j         <= 1'b0;
      k         <= 1'b0;
      tgt_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid && tgt_ready) begin
            tgt_q     <= tgt_bit;
            {j, k}    <= jk_calc;
            tgt_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          {j, k}  <= JK_HOLD;
          dly_cnt <= DLY_LOAD;
          state   <= CHECK;
        end
        CHECK: begin
          // Compare on the edge that ends the last CHECK cycle
          if (dly_cnt <= 4'd1) begin
            done      <= 1'b1;
            err       <= (q_in != tgt_q);
            tgt_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear takes priority over a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Self-checking bench for jk_drive_ctrl with a behavioural J-K flop and a scoreboard.
module tb_jk_drive_ctrl;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       tgt_bit = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       q_model = 1'b0;
  logic       stuck = 1'b0;
  logic       q_zero = 1'b0;

  logic       tgt_ready, j, k, busy, done, err;
  logic [7:0] err_cnt;
  logic       tgt_ready_b, j_b, k_b, busy_b, done_b, err_b;
  logic [1:0] err_cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;

  typedef struct {
    logic e;
    int   t0;
  } sb_t;
  sb_t sb[$];

  logic       drive_pend = 1'b0;
  logic [1:0] drive_jk = 2'b00;

  jk_drive_ctrl #(.CNT_W(8), .CHK_DLY(D)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(tgt_ready), .q_in(q_model), .j(j), .k(k), .busy(busy),
    .done(done), .err(err), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
  );

  // Narrow counter instance whose flop is permanently stuck at 0
  jk_drive_ctrl #(.CNT_W(2), .CHK_DLY(D)) dut_b (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(tgt_ready_b), .q_in(q_zero), .j(j_b), .k(k_b), .busy(busy_b),
    .done(done_b), .err(err_b), .err_cnt(err_cnt_b), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (stuck) q_model <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

  function automatic logic [1:0] excite(input logic qc, input logic t);
    if (qc == t) return 2'b00;
`ifdef JKDRV_TOGGLE_EN
    return 2'b11;
`else
    return t ? 2'b10 : 2'b01;
`endif
  endfunction

  // Scoreboard monitor: push on handshake, check drive cycle, pop on done
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      drive_pend = 1'b0;
    end else begin
      checks++;
      if (drive_pend) begin
        if ({j, k} !== drive_jk || busy !== 1'b1) begin
          errors++;
          $display("FAIL drive_jk: got jk=%b busy=%b, expected jk=%b busy=1", {j, k}, busy, drive_jk);
        end
        drive_pend = 1'b0;
      end else if ((j | k) !== 1'b0) begin
        errors++;
        $display("FAIL idle_jk: got jk=%b outside DRIVE, expected 00", {j, k});
      end
      checks++;
      if (busy === 1'b1 && tgt_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy: tgt_ready=%b while busy, expected 0", tgt_ready);
      end
      if (done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=1 with no outstanding target");
        end else begin
          sb_t s;
          s = sb.pop_front();
          if (err !== s.e || (cyc - s.t0) != D + 2) begin
            errors++;
            $display("FAIL done_err: got err=%b latency=%0d, expected err=%b latency=%0d",
                     err, cyc - s.t0, s.e, D + 2);
          end else begin
            $display("txn done: err=%b latency=%0d", err, cyc - s.t0);
          end
        end
      end else begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL err_without_done: err=%b, expected 0", err);
        end
      end
      if (tgt_valid === 1'b1 && tgt_ready === 1'b1) begin
        sb_t s;
        s.e  = stuck ? (tgt_bit != 1'b0) : 1'b0;
        s.t0 = cyc;
        sb.push_back(s);
        drive_jk   = excite(q_model, tgt_bit);
        drive_pend = 1'b1;
        hs_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    logic fire;
    bit   ok;
    ok = 1'b0;
    tgt_valid = 1'b1;
    tgt_bit   = b;
    for (int c = 0; c < 50; c++) begin
      fire = tgt_ready;
      tick();
      if (fire) begin
        ok = 1'b1;
        break;
      end
    end
    tgt_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: target %b not accepted within 50 cycles", b);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({j, k, tgt_ready, busy, done, err} !== 6'b001000 || err_cnt !== 8'd0 || err_cnt_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: j=%b k=%b ready=%b busy=%b done=%b err=%b cnt=%0d cnt_b=%0d, expected 0 0 1 0 0 0 0 0",
               j, k, tgt_ready, busy, done, err, err_cnt, err_cnt_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_set_hold();
    send(1'b1);
    wait_done();
    send(1'b1);
    wait_done();
    tick();
    checks++;
    if (q_model !== 1'b1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL set_hold: q=%b cnt=%0d, expected q=1 cnt=0", q_model, err_cnt);
    end
  endtask

  task automatic test_reset_build();
    send(1'b0);
    wait_done();
    tick();
    checks++;
    if (q_model !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drive: q=%b cnt=%0d, expected q=0 cnt=0", q_model, err_cnt);
    end
  endtask

  task automatic test_mismatch();
    stuck = 1'b1;
    repeat (5) begin
      send(1'b1);
      wait_done();
    end
    tick();
    checks++;
    if (err_cnt !== 8'd5) begin
      errors++;
      $display("FAIL mismatch_count: err_cnt=%0d, expected 5", err_cnt);
    end
    send(1'b1);
    wait_done();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_vs_err: err_cnt=%0d, expected 0", err_cnt);
    end
    tick();
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_after: err_cnt=%0d, expected 0", err_cnt);
    end
    stuck = 1'b0;
  endtask

  task automatic test_saturation();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    stuck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(1'b1);
      wait_done();
      tick();
      checks++;
      if (err_cnt_b !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        errors++;
        $display("FAIL saturation: err_cnt_b=%0d after %0d errors, expected %0d",
                 err_cnt_b, i + 1, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    checks++;
    if (err_cnt !== 8'd6) begin
      errors++;
      $display("FAIL wide_count: err_cnt=%0d, expected 6", err_cnt);
    end
    stuck = 1'b0;
  endtask

  task automatic test_midreset();
    int seen_done;
    checks++;
    if (err_cnt === 8'd0) begin
      errors++;
      $display("FAIL midreset_pre: err_cnt=0, expected nonzero before reset");
    end
    send(1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({j, k, tgt_ready, busy, done} !== 5'b00100 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset: j=%b k=%b ready=%b busy=%b done=%b cnt=%0d, expected 0 0 1 0 0 0",
               j, k, tgt_ready, busy, done, err_cnt);
    end
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    repeat (8) begin
      tick();
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_done: %0d done pulses after abort, expected 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    int   prev;
    int   start;
    logic fire;
    logic last_bit;
    n = 0;
    prev = 0;
    start = hs_count;
    last_bit = 1'b0;
    tgt_valid = 1'b1;
    tgt_bit = ~q_model;
    for (int c = 0; c < 100 && n < 6; c++) begin
      fire = tgt_ready;
      tick();
      if (fire) begin
        if (n > 0) begin
          checks++;
          if (cyc - prev != D + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", cyc - prev, D + 2);
          end
        end
        prev = cyc;
        n++;
        last_bit = tgt_bit;
        tgt_bit = ~tgt_bit;
      end
    end
    tgt_valid = 1'b0;
    wait_done();
    tick();
    checks++;
    if (n != 6 || hs_count - start != 6 || sb.size() != 0 || q_model !== last_bit) begin
      errors++;
      $display("FAIL b2b_total: seen=%0d accepted=%0d pending=%0d q=%b, expected 6 6 0 %b",
               n, hs_count - start, sb.size(), q_model, last_bit);
    end
  endtask

  initial begin
    test_reset();
    test_set_hold();
    test_reset_build();
    test_mismatch();
    test_saturation();
    test_midreset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_drive_ctrl.md
# jk_drive_ctrl

Drives a discrete J-K flip-flop to a requested sequence of output values and checks that it got there. Target bits arrive over a valid/ready handshake. For each bit the block computes the J/K excitation from the flop's current `q`, drives it for one clock, then reads `q` back and flags any mismatch. It sits upstream of the JK flip-flop as its command source and self-checker on the shared `clk`.

## Interface
Parameters:
- `CNT_W`, 8: width of the saturating error counter.
- `CHK_DLY`, 1: number of CHECK cycles before `q` is compared; legal range 1–15.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `tgt_valid`: input, 1 bit. A target bit is offered.
- `tgt_bit`: input, 1 bit. Requested next value of `q`.
- `tgt_ready`: output, 1 bit. Block can accept a target.
- `q_in`: input, 1 bit. The flop's `q` output.
- `j`: output, 1 bit. J drive to the flop.
- `k`: output, 1 bit. K drive to the flop.
- `busy`: output, 1 bit. A transaction is in progress.
- `done`: output, 1 bit. One-cycle pulse when a transaction completes.
- `err`: output, 1 bit. One-cycle pulse, coincident with `done`, when `q_in` ≠ target.
- `err_cnt`: output, `CNT_W` bits. Count of mismatches, saturating.
- `clr_cnt`: input, 1 bit. Synchronous clear of `err_cnt`.

## Operation
State machine with three states: IDLE, DRIVE, CHECK.

- **IDLE**
  - `tgt_ready`=1, `j`=`k`=0.
  - On `tgt_valid`&`tgt_ready`: latch `tgt_bit` into `tgt_q`, register J/K from the excitation rule using the current `q_in`, go to DRIVE.
- **DRIVE**
  - `j`/`k` hold the computed excitation for exactly one cycle.
  - `tgt_ready`=0.
  - Next state is CHECK; the delay counter loads `CHK_DLY`.
- **CHECK**
  - `j`=`k`=0 (hold).
  - The counter decrements each cycle.
  - At the edge ending the last CHECK cycle: compare `q_in` with `tgt_q`, register `done`=1, register `err`=(`q_in`≠`tgt_q`), go to IDLE.

Excitation rule, without the macro:
- `q_in`==target: `j`=0, `k`=0 (hold).
- `q_in`=0, target=1: `j`=1, `k`=0 (set).
- `q_in`=1, target=0: `j`=0, `k`=1 (reset).

Other rules:
- `busy`=1 in DRIVE and CHECK.
- `err_cnt` increments on an `err` pulse and saturates at 2^`CNT_W`−1.
- `clr_cnt` zeroes `err_cnt` at the next edge. If `clr_cnt` and an increment coincide, clear wins and the result is 0.
- `tgt_bit` is ignored unless the handshake fires. `tgt_valid` while `tgt_ready`=0 has no effect (no queueing).
- `q_in` is treated as synchronous to `clk`; no synchronizer.

## Timing
- Reset (asynchronous assert, synchronous-release usage): state IDLE, `j`=`k`=0, `tgt_ready`=1, `busy`=0, `done`=0, `err`=0, `err_cnt`=0, `tgt_q`=0.
- Handshake at edge t0 → `j`/`k` valid during cycle t0..t1 → flop captures at edge t1.
- `q_in` is compared at edge t1+`CHK_DLY`; `done`/`err` are high for the cycle following that edge.
- `tgt_ready` returns to 1 in the same cycle as `done`. A new handshake in that cycle is legal, giving back-to-back throughput of one bit per `CHK_DLY`+2 cycles.
- Reset mid-transaction aborts immediately: `j`/`k` drop to 0 asynchronously, no `done`/`err`, and `err_cnt` clears.

## Configuration
- `JKDRV_TOGGLE_EN` defined: a required change (`q_in`≠target) drives `j`=1, `k`=1 (toggle) instead of set/reset. Hold is unchanged.
- Undefined: set/reset encoding as in Operation.
- Final `q` is identical in both builds; only `j`/`k` during DRIVE differ.

## Structure
- Shared package `jk_pkg`:
  - State enum `jkdrv_state_t` {IDLE, DRIVE, CHECK}.
  - Constants for excitation pairs: `JK_HOLD`=2'b00, `JK_RESET`=2'b01, `JK_SET`=2'b10, `JK_TOGGLE`=2'b11, encoded as {j,k}.
- Sub-module `jk_excite`: combinational excitation lookup. Inputs `q_cur`, `q_next`; output {j,k}. Honours `JKDRV_TOGGLE_EN`.
- FSM, delay counter and error counter live in `jk_drive_ctrl`.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-DRIVE → `j`=`k`=0 immediately, `tgt_ready`=1, `err_cnt`=0, no `done`.
- **Set with hold:** flop at 0, send targets 1,1 → `j`/`k`=10 then 00 in DRIVE; two `done` pulses, `err`=0, `q`=1.
- **Reset, both builds:** flop at 1, send 0 → `j`/`k`=01 without the macro, 11 with `JKDRV_TOGGLE_EN`; `q`=0, `err`=0.
- **Mismatch detection:** flop model with `q` stuck at 0, send 1 five times → five `err` pulses, `err_cnt`=5; then `clr_cnt` coinciding with a sixth `err` → `err_cnt`=0.
- **Saturation:** `CNT_W`=2, stuck flop, 6 targets of 1 → `err_cnt` stops at 3.
- **Throughput and stall:** `CHK_DLY`=3, `tgt_valid` held high with alternating bits → handshakes exactly 5 cycles apart, `tgt_ready`=0 throughout `busy`, and no target is dropped or double-accepted.
